imem_fetch_controller: RTL

- Sequences the word-aligned, wrapping instruction memory: the single port that loads the program and fetches instructions.
- In LOAD mode it accepts program writes from the boot loader.
- In RUN mode it prefetches sequential words into a small FIFO and hands them to decode with a valid/ready handshake.
- Sits between the loader, the instruction memory and the decode stage; the branch unit redirects it.

---
 rtl/imem_fetch_controller.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_controller.sv
// ---------------------------------------------------------------------------
// imem_fetch_controller
//
// Owns the single port of the word-aligned, wrapping instruction memory.
// LOAD mode: the boot loader writes program words through the port.
// RUN mode: sequential words are prefetched into a small FIFO and handed to
// decode. A branch redirect flushes the FIFO and restarts fetch at a new PC.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready
// are both high. Valid never waits for ready; ready may depend on valid.
//   load_valid/load_ready : loader -> memory write
//   inst_valid/inst_ready : FIFO head -> decode
//
// Ports
//   clk, rst                        clock, async active-high reset
//   run                             1 = RUN (fetch), 0 = LOAD (program write)
//   load_valid/ready/addr/data      loader write channel (byte address)
//   imem_addr/wr_en/wr_data/rd_en   memory port; read data returns 1 cycle later
//   imem_rd_data                    read data
//   redirect_valid/redirect_pc      taken branch/jump, new fetch PC
//   inst_valid/ready/data/pc        instruction stream to decode
//
// Build option
//   IMEM_LOAD_IN_RUN_EN : loader writes are also accepted in RUN. A write
//   takes the port ahead of fetch, flushes the FIFO and re-fetches from the
//   oldest unconsumed instruction so modified code is picked up.
// ---------------------------------------------------------------------------
module imem_fetch_controller #(
    parameter int          ADDR_BITS  = 5,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [31:0]          load_addr,
    input  logic [31:0]          load_data,
    output logic [ADDR_BITS-1:0] imem_addr,
    output logic                 imem_wr_en,
    output logic [31:0]          imem_wr_data,
    output logic                 imem_rd_en,
    input  logic [31:0]          imem_rd_data,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [31:0]          inst_data,
    output logic [31:0]          inst_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [31:0]      fetch_pc, fetch_pc_next;
    logic             epoch;
    logic             inflight;
    logic [31:0]      tag_pc;
    logic             tag_epoch;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];

    logic             in_run;
    logic             load_in_run;
    logic             run_write;
    logic             write_en;
    logic             run_fall;
    logic             redirect_take;
    logic             flush;
    logic             issue;
    logic             rsp_push;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   occupancy;

    // Address bits outside the word index are don't-care by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{load_addr[31:ADDR_BITS+2], load_addr[1:0], redirect_pc[1:0]};

    assign in_run = (state == ST_RUN);

`ifdef IMEM_LOAD_IN_RUN_EN
    assign load_in_run = 1'b1;
`else
    assign load_in_run = 1'b0;
`endif

    assign load_ready    = ~rst & (~in_run | load_in_run);
    assign write_en      = load_valid & load_ready;
    assign run_write     = write_en & in_run;
    assign run_fall      = in_run & ~run;
    assign redirect_take = in_run & run & redirect_valid;

    // Every event that invalidates prefetched words; each also toggles the
    // epoch so a response still on its way back is discarded.
    assign flush = (~in_run & run) | run_fall | redirect_take | run_write;

    // count + inflight bounds the FIFO: a read is only launched when its
    // data is guaranteed a slot, so a push into a full FIFO cannot happen
    // without a simultaneous pop.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue     = in_run & run & ~redirect_valid & ~run_write &
                       (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    assign rsp_push   = inflight & (tag_epoch == epoch);
    assign push       = rsp_push & ~flush;
    assign inst_valid = in_run & (count != '0);
    assign pop        = inst_valid & inst_ready & ~flush;

    assign inst_data = inst_valid ? fifo_data[rd_ptr] : 32'h0;
    assign inst_pc   = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;

    // Memory port mux: a loader write owns the port in its cycle.
    assign imem_wr_en   = write_en;
    assign imem_wr_data = write_en ? load_data : 32'h0;
    assign imem_rd_en   = issue;
    assign imem_addr    = write_en ? load_addr[ADDR_BITS+1:2] :
                          issue    ? fetch_pc[ADDR_BITS+1:2]  : '0;

`ifdef IMEM_LOAD_IN_RUN_EN
    // PC of the oldest instruction decode has not yet taken, looking past
    // the head when it is being popped this very cycle.
    logic [31:0]      oldest_pc;
    logic [PTR_W-1:0] rd_ptr_plus1;

    assign rd_ptr_plus1 = rd_ptr + PTR_W'(1);

    always_comb begin
        oldest_pc = fetch_pc;
        if (count > CNT_W'(1) || (count == CNT_W'(1) && !(inst_valid && inst_ready)))
            oldest_pc = (inst_valid && inst_ready) ? fifo_pc[rd_ptr_plus1] : fifo_pc[rd_ptr];
        else if (rsp_push)
            oldest_pc = tag_pc;
    end
`endif

    // Next-state and next fetch PC.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        case (state)
            ST_LOAD: begin
                if (run) begin
                    state_next    = ST_RUN;
                    fetch_pc_next = RESET_PC;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_next = ST_LOAD;
                end else if (redirect_valid) begin
                    fetch_pc_next = {redirect_pc[31:2], 2'b00};
                end else if (run_write) begin
`ifdef IMEM_LOAD_IN_RUN_EN
                    fetch_pc_next = oldest_pc;
`endif
                end else if (issue) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            fetch_pc  <= RESET_PC;
            epoch     <= 1'b0;
            inflight  <= 1'b0;
            tag_pc    <= 32'h0;
            tag_epoch <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            epoch    <= epoch ^ flush;
            inflight <= issue;
            if (issue) begin
                tag_pc    <= fetch_pc;
                tag_epoch <= epoch;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
            end
        end
    end

    // FIFO storage needs no reset: contents are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rd_data;
            fifo_pc[wr_ptr]   <= tag_pc;
        end
    end

endmodule
